register_window_controller: RTL
===============================

Name: register_window_controller

Overview:
Manages SPARC register windows for the register file. It holds the Current Window Pointer (CWP) and the Window Invalid Mask (WIM), and sequences SAVE, RESTORE, trap-entry and CWP-write operations. It flags window overflow and underflow. It translates the 5-bit architectural register selects for read ports A and B and write port D into physical register indices, which drive the register file read muxes and the write decoder.

Parameters:
NWINDOWS, 4, number of register windows; power of 2, range 2..32
CWP_W, 2, CWP width; must equal log2(NWINDOWS)
PHYS_W, 7, physical index width; must satisfy 2^PHYS_W >= 8 + 16*NWINDOWS

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Save  input  1  request SAVE (CWP-1 with WIM check)
Restore  input  1  request RESTORE (CWP+1 with WIM check)
Trap_Entry  input  1  request trap entry (CWP-1, no WIM check)
CWP_Write  input  1  request load of CWP from CWP_In
CWP_In  input  5  new CWP value
WIM_Write  input  1  load WIM from WIM_In at the next edge
WIM_In  input  NWINDOWS  new WIM value
Register_A_Select  input  5  architectural index, read port A
Register_B_Select  input  5  architectural index, read port B
Register_D_Select  input  5  architectural index, write port
Phys_A  output  PHYS_W  physical index for read port A
Phys_B  output  PHYS_W  physical index for read port B
Phys_D  output  PHYS_W  physical index for the write port
CWP  output  CWP_W  current window pointer
WIM  output  NWINDOWS  window invalid mask
Busy  output  1  operation in progress; new requests are ignored while high
Op_Done  output  1  one-cycle pulse when any operation completes
Window_Overflow  output  1  one-cycle pulse: SAVE targeted an invalid window
Window_Underflow  output  1  one-cycle pulse: RESTORE targeted an invalid window

Behaviour:
- Reset (asynchronous, immediate): CWP=0, WIM=0, FSM=IDLE, Busy=0, Op_Done=0, Window_Overflow=0, Window_Underflow=0. Any in-flight operation is discarded without a pulse.
- Translation is combinational from the registered CWP and is identical for A, B and D:
  - sel 0..7 (globals): phys = sel.
  - sel 8..31: phys = 8 + ((CWP*16 + sel - 8) mod (16*NWINDOWS)).
  - The ins of window w therefore alias the outs of window (w+1) mod NWINDOWS.
  - Keeping r0 at zero is the register file's job, not this block's.
- FSM states: IDLE and EXEC.
  - IDLE: when any of Save, Restore, Trap_Entry or CWP_Write is high at a rising edge, latch the single highest-priority op (and CWP_In if applicable) and go to EXEC.
  - Priority: Trap_Entry > CWP_Write > Save > Restore. Lower-priority simultaneous requests are dropped, not queued.
  - EXEC: Busy=1. Requests are ignored. At the next edge, commit the op, register the pulses and return to IDLE.
- Latency: request sampled at edge of cycle N. Busy=1 during cycle N+1. In cycle N+2: new CWP visible, Op_Done=1 (plus any flag), Busy=0. A new request may be sampled at the end of cycle N+2.
- Commit rules (arithmetic mod NWINDOWS):
  - Save: tgt = CWP-1. If WIM[tgt]=1, Window_Overflow=1 and CWP is unchanged; else CWP=tgt.
  - Restore: tgt = CWP+1. If WIM[tgt]=1, Window_Underflow=1 and CWP is unchanged; else CWP=tgt.
  - Trap_Entry: CWP = CWP-1 unconditionally; no flag.
  - CWP_Write: if CWP_In < NWINDOWS, CWP = CWP_In; else CWP is unchanged and no flag is raised.
- Op_Done pulses for every committed op, including trapped and ignored ones. Overflow and underflow flags are never both high.
- WIM_Write is accepted in any state, independent of the FSM, and updates WIM at the edge. A WIM check in EXEC uses the WIM value registered before that edge.
- Wrap-around: CWP 0 -> NWINDOWS-1 on Save/Trap_Entry; NWINDOWS-1 -> 0 on Restore.

Test Plan:
(all scenarios use NWINDOWS=4)
1. Reset released -> CWP=0, WIM=0, Busy=0. Select 5 -> Phys 5. Select 24 -> Phys 24. Select 8 -> Phys 8.
2. CWP=0, WIM=0, Save pulsed in cycle N -> Busy=1 in N+1. In N+2: CWP=3, Op_Done=1, no flags. Select 24 -> Phys 8, which equals r8's index at CWP=0.
3. WIM_Write with 4'b0100 at CWP=3, then Save -> Window_Overflow=1 and Op_Done=1 in N+2; CWP stays 3.
4. CWP=3, WIM=4'b0001, Restore -> Window_Underflow=1, CWP=3. Then WIM=0 and Restore -> CWP=0 (wrap).
5. CWP=0, WIM=4'b1000, Trap_Entry and Save high in the same cycle -> CWP=3, no overflow, one Op_Done. A Save asserted in the Busy cycle is ignored (CWP remains 3). CWP_Write with CWP_In=6 -> CWP unchanged, Op_Done=1.
6. Reset asserted during EXEC of a Save -> CWP=0 and Busy=0 immediately. No Op_Done after release.

Source files
------------

// File: rtl/register_window_controller.sv
// SPARC register window controller: holds CWP/WIM, sequences SAVE/RESTORE/trap/CWP writes
// and maps architectural register selects onto physical register file indices.
module register_window_controller #(
  parameter int NWINDOWS = 4,
  parameter int CWP_W    = 2,
  parameter int PHYS_W   = 7
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Save,
  input  logic                Restore,
  input  logic                Trap_Entry,
  input  logic                CWP_Write,
  input  logic [4:0]          CWP_In,
  input  logic                WIM_Write,
  input  logic [NWINDOWS-1:0] WIM_In,
  input  logic [4:0]          Register_A_Select,
  input  logic [4:0]          Register_B_Select,
  input  logic [4:0]          Register_D_Select,
  output logic [PHYS_W-1:0]   Phys_A,
  output logic [PHYS_W-1:0]   Phys_B,
  output logic [PHYS_W-1:0]   Phys_D,
  output logic [CWP_W-1:0]    CWP,
  output logic [NWINDOWS-1:0] WIM,
  output logic                Busy,
  output logic                Op_Done,
  output logic                Window_Overflow,
  output logic                Window_Underflow
);

  localparam int WIN_W = CWP_W + 4;
  localparam logic [CWP_W-1:0] CWP_ONE = 1;

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {OP_SAVE, OP_RESTORE, OP_TRAP, OP_WRCWP} op_t;

  state_t             state, next_state;
  op_t                op_q, req_op;
  logic               req_any;
  logic [4:0]         cwp_in_q;
  logic [CWP_W-1:0]   cwp_q;
  logic [NWINDOWS-1:0] wim_q;
  logic [CWP_W-1:0]   dec_tgt, inc_tgt;
  logic               op_done_q, overflow_q, underflow_q;

  // Windowed registers live in a ring of 16*NWINDOWS entries above the 8 globals;
  // the power-of-two ring size lets the modulo fall out of the truncated add.
  function automatic logic [PHYS_W-1:0] translate(input logic [4:0] sel,
                                                  input logic [CWP_W-1:0] w);
    logic [4:0]       rel;
    logic [WIN_W-1:0] off;
    if (sel < 5'd8) begin
      return PHYS_W'(sel);
    end
    rel = sel - 5'd8;
    off = {w, 4'b0000} + WIN_W'(rel);
    return PHYS_W'(off) + PHYS_W'(8);
  endfunction

  assign Phys_A = translate(Register_A_Select, cwp_q);
  assign Phys_B = translate(Register_B_Select, cwp_q);
  assign Phys_D = translate(Register_D_Select, cwp_q);

  assign dec_tgt = cwp_q - CWP_ONE;
  assign inc_tgt = cwp_q + CWP_ONE;

  always_comb begin
    req_any = Trap_Entry | CWP_Write | Save | Restore;
    req_op  = OP_RESTORE;
    if (Trap_Entry)     req_op = OP_TRAP;
    else if (CWP_Write) req_op = OP_WRCWP;
    else if (Save)      req_op = OP_SAVE;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_any) next_state = EXEC;
      EXEC: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == EXEC);
  end

  // Only the winning request is captured; lower-priority ones are dropped.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q     <= OP_SAVE;
      cwp_in_q <= 5'd0;
    end else if (state == IDLE && req_any) begin
      op_q     <= req_op;
      cwp_in_q <= CWP_In;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cwp_q       <= '0;
      op_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      op_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      if (state == EXEC) begin
        op_done_q <= 1'b1;
        case (op_q)
          OP_SAVE: begin
            if (wim_q[dec_tgt]) overflow_q <= 1'b1;
            else                cwp_q      <= dec_tgt;
          end
          OP_RESTORE: begin
            if (wim_q[inc_tgt]) underflow_q <= 1'b1;
            else                cwp_q       <= inc_tgt;
          end
          OP_TRAP: cwp_q <= dec_tgt;
          OP_WRCWP: begin
            if ({27'd0, cwp_in_q} < NWINDOWS) cwp_q <= cwp_in_q[CWP_W-1:0];
          end
          default: cwp_q <= cwp_q;
        endcase
      end
    end
  end

  // WIM is software-owned and updates regardless of FSM state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)          wim_q <= '0;
    else if (WIM_Write) wim_q <= WIM_In;
  end

  assign CWP              = cwp_q;
  assign WIM              = wim_q;
  assign Op_Done          = op_done_q;
  assign Window_Overflow  = overflow_q;
  assign Window_Underflow = underflow_q;

endmodule
